// File: rtl/mem_pkg.sv
// Shared types and default address constants for the memory responder.
package mem_pkg;

   // Bus command encoding; 2'b11 is illegal and is deliberately left out of the enum
   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_t;

   // Responder sequencing: accept, optional wait states, one access cycle, one response cycle
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT   = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } resp_state_t;

   localparam logic [8:0] DEF_LED_ADDR = 9'h100;
   localparam logic [8:0] DEF_SW_ADDR  = 9'h140;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Contents and the read register are intentionally not reset.
module ram_sp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write and read share the one port; the read register only moves when re is asserted
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: 256-word RAM plus LED and switch I/O registers,
// with programmable wait states and a one-cycle mem_ready completion pulse.
module mem_responder
   import mem_pkg::*;
#(
   parameter int                ADDR_W      = 9,
   parameter int                DATA_W      = 16,
   parameter int                WAIT_STATES = 1,
   parameter logic [ADDR_W-1:0] LED_ADDR    = DEF_LED_ADDR,
   parameter logic [ADDR_W-1:0] SW_ADDR     = DEF_SW_ADDR
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mem_cmd,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [7:0]        sw,
   output logic [DATA_W-1:0] read_data,
   output logic              mem_ready,
   output logic [7:0]        leds,
   output logic              err
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   resp_state_t       state;
   logic [3:0]        wait_cnt;
   mem_cmd_t          cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] io_rdata;
   logic              rd_from_ram;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_sel;
   logic              ram_we;
   logic              ram_re;

   // The RAM is touched only in ACCESS and only from the latched request
   assign ram_sel = ~addr_q[ADDR_W-1];
   assign ram_we  = (state == ACCESS) && (cmd_q == MWRITE) && ram_sel;
   assign ram_re  = (state == ACCESS) && (cmd_q == MREAD) && ram_sel;

   ram_sp #(
      .ADDR_W(8),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (ram_re),
      .addr (addr_q[7:0]),
      .wdata(wdata_q),
      .rdata(ram_rdata)
   );

   // read_data follows whichever source served the last read; both sources only move on reads
   assign read_data = rd_from_ram ? ram_rdata : io_rdata;

   // Request sequencing, address decode and I/O registers in one registered FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         cmd_q       <= MNONE;
         addr_q      <= '0;
         wdata_q     <= '0;
         io_rdata    <= '0;
         rd_from_ram <= 1'b0;
         mem_ready   <= 1'b0;
         leds        <= 8'h00;
         err         <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
                  cmd_q    <= mem_cmd_t'(mem_cmd);
                  addr_q   <= mem_addr;
                  wdata_q  <= write_data;
                  wait_cnt <= WAIT_INIT;
                  state    <= (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
               end else if (mem_cmd == 2'b11) begin
                  err <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
               if (wait_cnt <= 4'd1) begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               state     <= RESP;
               mem_ready <= 1'b1;
               if (ram_sel) begin
                  if (cmd_q == MREAD) begin
                     rd_from_ram <= 1'b1;
                  end
               end else if (addr_q == LED_ADDR) begin
                  if (cmd_q == MWRITE) begin
                     leds <= wdata_q[7:0];
                  end else begin
                     rd_from_ram <= 1'b0;
                     io_rdata    <= {{(DATA_W-8){1'b0}}, leds};
                  end
               end else if (addr_q == SW_ADDR) begin
                  if (cmd_q == MWRITE) begin
                     err <= 1'b1;
                  end else begin
                     rd_from_ram <= 1'b0;
                     io_rdata    <= {{(DATA_W-8){1'b0}}, sw};
                  end
               end else begin
                  err <= 1'b1;
                  if (cmd_q == MREAD) begin
                     rd_from_ram <= 1'b0;
                     io_rdata    <= '0;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with three instances (0, 1 and 3 wait states)
// sharing clock, reset, address, data and switches but with separate commands.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  cmd0, cmd1, cmd3;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [7:0]  sw;

   logic [15:0] rd0, rd1, rd3;
   logic        rdy0, rdy1, rdy3;
   logic [7:0]  leds0, leds1, leds3;
   logic        err0, err1, err3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(reset_n), .mem_cmd(cmd0), .mem_addr(mem_addr),
      .write_data(write_data), .sw(sw), .read_data(rd0), .mem_ready(rdy0),
      .leds(leds0), .err(err0)
   );

   mem_responder #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset_n(reset_n), .mem_cmd(cmd1), .mem_addr(mem_addr),
      .write_data(write_data), .sw(sw), .read_data(rd1), .mem_ready(rdy1),
      .leds(leds1), .err(err1)
   );

   mem_responder #(.WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(reset_n), .mem_cmd(cmd3), .mem_addr(mem_addr),
      .write_data(write_data), .sw(sw), .read_data(rd3), .mem_ready(rdy3),
      .leds(leds3), .err(err3)
   );

   function automatic logic get_ready(input int inst);
      case (inst)
         0:       return rdy0;
         1:       return rdy1;
         default: return rdy3;
      endcase
   endfunction

   // Issue one request to an instance; lat is the number of edges after the accepting
   // edge before mem_ready is seen (-1 on timeout), ready_after is mem_ready one cycle later.
   task automatic run_req(input int inst, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data, input bit scramble,
                          output int lat, output logic ready_after);
      @(negedge clk);
      case (inst)
         0:       cmd0 = cmd;
         1:       cmd1 = cmd;
         default: cmd3 = cmd;
      endcase
      mem_addr   = addr;
      write_data = data;
      @(posedge clk);
      @(negedge clk);
      cmd0 = 2'b00;
      cmd1 = 2'b00;
      cmd3 = 2'b00;
      if (scramble) begin
         mem_addr   = addr ^ 9'h001;
         write_data = ~data;
      end
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         if (get_ready(inst)) begin
            lat = k;
            break;
         end
      end
      @(negedge clk);
      ready_after = get_ready(inst);
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      cmd0 = 2'b00; cmd1 = 2'b00; cmd3 = 2'b00;
      mem_addr = 9'h000; write_data = 16'h0000; sw = 8'h00;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rd1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_read_data got %h want 0000", rd1); end
      checks++; if (rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_ready got %b want 0", rdy1); end
      checks++; if (leds1 !== 8'h00) begin errors++; $display("[TB] FAIL reset_leds got %h want 00", leds1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err1); end
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic ra;
      run_req(1, 2'b10, 9'h005, 16'hBEEF, 1'b0, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL wr_latency got %0d want 2", lat); end
      checks++; if (ra !== 1'b0) begin errors++; $display("[TB] FAIL wr_pulse_width got %b want 0", ra); end
      run_req(1, 2'b01, 9'h005, 16'h0000, 1'b0, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL rd_latency got %0d want 2", lat); end
      checks++; if (ra !== 1'b0) begin errors++; $display("[TB] FAIL rd_pulse_width got %b want 0", ra); end
      checks++; if (rd1 !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_data got %h want BEEF", rd1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL rd_err got %b want 0", err1); end
   endtask

   task automatic test_led_switch();
      int lat; logic ra;
      run_req(1, 2'b10, 9'h100, 16'h12A5, 1'b0, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL led_wr_latency got %0d want 2", lat); end
      checks++; if (leds1 !== 8'hA5) begin errors++; $display("[TB] FAIL led_value got %h want A5", leds1); end
      run_req(1, 2'b01, 9'h100, 16'h0000, 1'b0, lat, ra);
      checks++; if (rd1 !== 16'h00A5) begin errors++; $display("[TB] FAIL led_readback got %h want 00A5", rd1); end
      sw = 8'h3C;
      run_req(1, 2'b01, 9'h140, 16'h0000, 1'b0, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL sw_rd_latency got %0d want 2", lat); end
      checks++; if (rd1 !== 16'h003C) begin errors++; $display("[TB] FAIL sw_read got %h want 003C", rd1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("[TB] FAIL sw_err got %b want 0", err1); end
   endtask

   task automatic test_errors();
      int lat; logic ra;
      run_req(1, 2'b10, 9'h1FF, 16'hFFFF, 1'b0, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bad_wr_latency got %0d want 2", lat); end
      checks++; if (err1 !== 1'b1) begin errors++; $display("[TB] FAIL bad_wr_err got %b want 1", err1); end
      checks++; if (rd1 !== 16'h003C) begin errors++; $display("[TB] FAIL bad_wr_read_data got %h want 003C", rd1); end
      checks++; if (leds1 !== 8'hA5) begin errors++; $display("[TB] FAIL bad_wr_leds got %h want A5", leds1); end
      run_req(1, 2'b01, 9'h180, 16'h0000, 1'b0, lat, ra);
      checks++; if (rd1 !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_read got %h want 0000", rd1); end
   endtask

   task automatic test_busy_ignore();
      int lat; logic ra;
      run_req(1, 2'b10, 9'h021, 16'h0F0F, 1'b0, lat, ra);
      run_req(1, 2'b10, 9'h020, 16'hA1B2, 1'b1, lat, ra);
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL busy_wr_latency got %0d want 2", lat); end
      run_req(1, 2'b01, 9'h020, 16'h0000, 1'b0, lat, ra);
      checks++; if (rd1 !== 16'hA1B2) begin errors++; $display("[TB] FAIL busy_latched_data got %h want A1B2", rd1); end
      run_req(1, 2'b01, 9'h021, 16'h0000, 1'b0, lat, ra);
      checks++; if (rd1 !== 16'h0F0F) begin errors++; $display("[TB] FAIL busy_other_addr got %h want 0F0F", rd1); end
   endtask

   task automatic test_zero_wait();
      int lat; logic ra; int seen;
      run_req(0, 2'b10, 9'h000, 16'h0042, 1'b0, lat, ra);
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL ws0_wr_latency got %0d want 1", lat); end
      run_req(0, 2'b01, 9'h000, 16'h0000, 1'b0, lat, ra);
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL ws0_rd_latency got %0d want 1", lat); end
      checks++; if (ra !== 1'b0) begin errors++; $display("[TB] FAIL ws0_pulse_width got %b want 0", ra); end
      checks++; if (rd0 !== 16'h0042) begin errors++; $display("[TB] FAIL ws0_rd_data got %h want 0042", rd0); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("[TB] FAIL ws0_err_before got %b want 0", err0); end
      @(negedge clk);
      cmd0 = 2'b11;
      @(negedge clk);
      cmd0 = 2'b00;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (rdy0) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL illegal_ready got %0d pulses want 0", seen); end
      checks++; if (err0 !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b want 1", err0); end
      checks++; if (rd0 !== 16'h0042) begin errors++; $display("[TB] FAIL illegal_read_data got %h want 0042", rd0); end
   endtask

   task automatic test_mid_reset();
      int lat; logic ra; int seen;
      run_req(3, 2'b10, 9'h010, 16'h1111, 1'b0, lat, ra);
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL ws3_wr_latency got %0d want 4", lat); end
      run_req(3, 2'b10, 9'h100, 16'h00C3, 1'b0, lat, ra);
      run_req(3, 2'b01, 9'h010, 16'h0000, 1'b0, lat, ra);
      checks++; if (rd3 !== 16'h1111) begin errors++; $display("[TB] FAIL ws3_rd_data got %h want 1111", rd3); end
      @(negedge clk);
      cmd3 = 2'b11;
      @(negedge clk);
      cmd3 = 2'b00;
      checks++; if (err3 !== 1'b1) begin errors++; $display("[TB] FAIL ws3_err_pre got %b want 1", err3); end
      // write that gets aborted before its access edge (edge 4)
      @(negedge clk);
      cmd3 = 2'b10; mem_addr = 9'h010; write_data = 16'h7777;
      @(posedge clk);
      @(negedge clk);
      cmd3 = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++; if (rd3 !== 16'h0000) begin errors++; $display("[TB] FAIL abort_read_data got %h want 0000", rd3); end
      checks++; if (leds3 !== 8'h00) begin errors++; $display("[TB] FAIL abort_leds got %h want 00", leds3); end
      checks++; if (err3 !== 1'b0) begin errors++; $display("[TB] FAIL abort_err got %b want 0", err3); end
      checks++; if (rdy3 !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready got %b want 0", rdy3); end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rdy3) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_ready got %0d pulses want 0", seen); end
      run_req(3, 2'b01, 9'h010, 16'h0000, 1'b0, lat, ra);
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL post_reset_latency got %0d want 4", lat); end
      checks++; if (rd3 !== 16'h1111) begin errors++; $display("[TB] FAIL abort_not_committed got %h want 1111", rd3); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_led_switch();
      test_errors();
      test_busy_ignore();
      test_zero_wait();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
